// File: rtl/sd_rd_fifo_if.sv
// ---------------------------------------------------------------------------
// sd_rd_fifo_if
// Byte stream bundle between the SD read path, the read FIFO and the UART.
//   wr_en / wr_data   : byte strobe into the FIFO
//   full              : FIFO storage holds DEPTH bytes
//   tx_valid/tx_data  : FIFO output register toward the UART
//   tx_ready          : UART accepts the byte on tx_valid & tx_ready
//   fifo_done         : one-cycle end-of-sector pulse
//   overflow          : sticky write-while-full flag
// Modports: master = SD reader / UART side, slave = the FIFO.
// ---------------------------------------------------------------------------
interface sd_rd_fifo_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       fifo_done;
    logic       overflow;

    modport master (
        output wr_en, wr_data, tx_ready,
        input  full, tx_valid, tx_data, fifo_done, overflow
    );

    modport slave (
        input  wr_en, wr_data, tx_ready,
        output full, tx_valid, tx_data, fifo_done, overflow
    );
endinterface

// File: rtl/sd_rd_fifo.sv
// ---------------------------------------------------------------------------
// sd_rd_fifo
// Byte FIFO between the SD sector reader and the UART transmitter. Bytes are
// stored in a DEPTH x 8 circular memory, moved into a single output register
// (tx_valid/tx_data) and handed to the UART with a valid/ready handshake.
// Handshakes are counted; fifo_done pulses for one cycle after the final
// byte of each SECTOR_BYTES-byte sector.
//
// Ports:
//   sd_ck  : clock, rising edge
//   rst    : synchronous active-high reset
//   clr    : synchronous flush, same effect as rst
//   bus    : sd_rd_fifo_if.slave (wr_en, wr_data, full, tx_valid, tx_data,
//            tx_ready, fifo_done, overflow)
//
// Build option: define SD_FIFO_OVF_EN to build the sticky overflow flag;
// otherwise overflow is tied low. Dropped writes behave the same either way.
// ---------------------------------------------------------------------------
module sd_rd_fifo #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int SECTOR_BYTES = 512
) (
    input  logic          sd_ck,
    input  logic          rst,
    input  logic          clr,
    sd_rd_fifo_if.slave   bus
);

    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [9:0]  SEC_LAST = 10'(SECTOR_BYTES - 1);

    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          full_reg;
    logic          tx_valid_reg;
    logic [7:0]    tx_data_reg;
    logic [9:0]    sec_cnt_reg;
    logic          fifo_done_reg;

    logic          flush;
    logic          wr_accept;
    logic          load;
    logic          handshake;
    logic          sec_last;

    always_comb begin
        flush     = rst | clr;
        // full_reg always equals (count_reg == DEPTH), so it gates writes
        wr_accept = bus.wr_en & ~full_reg;
        load      = (count_reg != '0) & (~tx_valid_reg | bus.tx_ready);
        handshake = tx_valid_reg & bus.tx_ready;
        sec_last  = (sec_cnt_reg == SEC_LAST);

        count_next = count_reg;
        case ({wr_accept, load})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage array: no reset so it maps onto block/distributed RAM.
    // A write and a load never target the same entry: the load reads an
    // occupied slot, the write fills a free one.
    always_ff @(posedge sd_ck) begin
        if (wr_accept && !flush) begin
            mem[wr_ptr_reg] <= bus.wr_data;
        end
    end

    always_ff @(posedge sd_ck) begin
        if (flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            full_reg      <= 1'b0;
            tx_valid_reg  <= 1'b0;
            tx_data_reg   <= 8'h00;
            sec_cnt_reg   <= '0;
            fifo_done_reg <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end

            // Registered read: the output stage is the RAM read register
            if (load) begin
                tx_data_reg  <= mem[rd_ptr_reg];
                tx_valid_reg <= 1'b1;
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
            end else if (handshake) begin
                tx_valid_reg <= 1'b0;
            end

            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_C);

            if (handshake) begin
                sec_cnt_reg <= sec_last ? 10'd0 : sec_cnt_reg + 10'd1;
            end
            fifo_done_reg <= handshake & sec_last;
        end
    end

`ifdef SD_FIFO_OVF_EN
    logic overflow_reg;

    always_ff @(posedge sd_ck) begin
        if (flush) begin
            overflow_reg <= 1'b0;
        end else if (bus.wr_en && full_reg) begin
            overflow_reg <= 1'b1;
        end
    end

    assign bus.overflow = overflow_reg;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.full      = full_reg;
    assign bus.tx_valid  = tx_valid_reg;
    assign bus.tx_data   = tx_data_reg;
    assign bus.fifo_done = fifo_done_reg;

endmodule

// File: tb/tb_sd_rd_fifo.sv
// ---------------------------------------------------------------------------
// tb_sd_rd_fifo
// Self-checking bench for sd_rd_fifo (DEPTH=16, SECTOR_BYTES=512).
// A queue-based reference model tracks stored bytes, the output register,
// the handshake position within the sector and the overflow flag.
// ---------------------------------------------------------------------------
module tb_sd_rd_fifo;

    localparam int DEPTH  = 16;
    localparam int SECTOR = 512;

    logic sd_ck = 1'b0;
    logic rst;
    logic clr;

    always #5 sd_ck = ~sd_ck;

    sd_rd_fifo_if bus ();

    sd_rd_fifo #(
        .DEPTH        (DEPTH),
        .AW           (4),
        .SECTOR_BYTES (SECTOR)
    ) dut (
        .sd_ck (sd_ck),
        .rst   (rst),
        .clr   (clr),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [7:0] m_q[$];
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_full;
    logic       m_done;
    logic       m_ovf;
    int         m_sec;

    logic [7:0] delivered[$];
    int         done_seen;

    typedef struct {
        logic       c;
        logic       w;
        logic [7:0] d;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       ef;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic fl, input logic w, input logic [7:0] d,
                              input logic rdy);
        logic hs, ld, acc;
        if (fl) begin
            m_q.delete();
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_full  = 1'b0;
            m_done  = 1'b0;
            m_ovf   = 1'b0;
            m_sec   = 0;
        end else begin
            hs  = m_valid && rdy;
            ld  = (m_q.size() != 0) && (!m_valid || rdy);
            acc = w && (m_q.size() < DEPTH);
            m_done = hs && (m_sec == SECTOR - 1);
            if (hs) m_sec = (m_sec + 1) % SECTOR;
            if (ld) begin
                m_data  = m_q.pop_front();
                m_valid = 1'b1;
            end else if (hs) begin
                m_valid = 1'b0;
            end
            if (acc) m_q.push_back(d);
`ifdef SD_FIFO_OVF_EN
            if (w && !acc) m_ovf = 1'b1;
`endif
            m_full = (m_q.size() == DEPTH);
        end
    endtask

    // One clock cycle: drive inputs, clock, advance model, compare outputs.
    task automatic drive(input logic r, input logic c, input logic w,
                         input logic [7:0] d, input logic rdy);
        rst = r;
        clr = c;
        bus.wr_en    = w;
        bus.wr_data  = d;
        bus.tx_ready = rdy;
        if (!r && !c && bus.tx_valid && rdy) delivered.push_back(bus.tx_data);
        @(posedge sd_ck);
        model_step(r | c, w, d, rdy);
        #1;
        if (bus.fifo_done) done_seen++;
        chk("tx_valid",  bus.tx_valid,  m_valid);
        chk("tx_data",   bus.tx_data,   m_data);
        chk("full",      bus.full,      m_full);
        chk("fifo_done", bus.fifo_done, m_done);
        chk("overflow",  bus.overflow,  m_ovf);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        delivered.delete();
        done_seen = 0;
    endtask

    initial begin
        int bad;
        int sent;
        logic exp_ovf;

`ifdef SD_FIFO_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        rst = 1'b1;
        clr = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = 8'h00;
        bus.tx_ready = 1'b0;
        m_q.delete();
        m_valid = 1'b0; m_data = 8'h00; m_full = 1'b0;
        m_done = 1'b0; m_ovf = 1'b0; m_sec = 0;

        // ---------------- table-driven vectors ----------------
        //           c  w  d      rdy  ev  ed     ef
        tbl[0] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 8'h3C, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};

        do_reset();
        chk("reset_valid",    bus.tx_valid,  1'b0);
        chk("reset_data",     bus.tx_data,   8'h00);
        chk("reset_full",     bus.full,      1'b0);
        chk("reset_done",     bus.fifo_done, 1'b0);
        chk("reset_overflow", bus.overflow,  1'b0);

        for (int i = 0; i < 10; i++) begin
            drive(1'b0, tbl[i].c, tbl[i].w, tbl[i].d, tbl[i].rdy);
            chk("vec_valid", bus.tx_valid, tbl[i].ev);
            chk("vec_data",  bus.tx_data,  tbl[i].ed);
            chk("vec_full",  bus.full,     tbl[i].ef);
            $display("vec %0d: clr=%0b wr=%0b d=%02h rdy=%0b -> valid=%0b data=%02h full=%0b",
                     i, tbl[i].c, tbl[i].w, tbl[i].d, tbl[i].rdy,
                     bus.tx_valid, bus.tx_data, bus.full);
        end

        // ---------------- fill and overflow ----------------
        do_reset();
        for (int i = 0; i < 18; i++) drive(1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
        chk("fill_full",     bus.full,     1'b1);
        chk("fill_overflow", bus.overflow, exp_ovf);
        chk("fill_head",     bus.tx_data,  8'h00);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("fill_drain_len", delivered.size(), 17);
        bad = 0;
        for (int i = 0; i < delivered.size(); i++) if (delivered[i] != 8'(i)) bad++;
        chk("fill_drain_order", bad, 0);
        $display("fill: delivered %0d bytes, overflow=%0b", delivered.size(), bus.overflow);

        // ---------------- simultaneous write/pop, full write with pop ----------------
        do_reset();
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        chk("simul_count_before", dut.count_reg, 5);
        drive(1'b0, 1'b0, 1'b1, 8'h46, 1'b1);
        chk("simul_count_after", dut.count_reg, 5);
        for (int i = 0; i < 11; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'h47 + i), 1'b0);
        chk("simul_full", bus.full, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
        chk("full_pop_count", dut.count_reg, 15);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("simul_len", delivered.size(), 18);
        bad = 0;
        for (int i = 0; i < delivered.size(); i++) if (delivered[i] != 8'(8'h40 + i)) bad++;
        chk("simul_order", bad, 0);
        $display("simul: delivered %0d bytes", delivered.size());

        // ---------------- pointer wrap with random ready ----------------
        do_reset();
        sent = 0;
        for (int cyc = 0; cyc < 2000 && delivered.size() < 40; cyc++) begin
            logic w;
            w = (sent < 40) && !bus.full;
            drive(1'b0, 1'b0, w, 8'(sent), 1'($urandom_range(0, 1)));
            if (w) sent++;
        end
        chk("wrap_len", delivered.size(), 40);
        bad = 0;
        for (int i = 0; i < delivered.size(); i++) if (delivered[i] != 8'(i)) bad++;
        chk("wrap_order", bad, 0);
        chk("wrap_overflow", bus.overflow, 1'b0);
        $display("wrap: delivered %0d bytes", delivered.size());

        // ---------------- full sector streaming ----------------
        do_reset();
        for (int i = 0; i < SECTOR + 4; i++) drive(1'b0, 1'b0, i < SECTOR, 8'(i), 1'b1);
        chk("stream_len", delivered.size(), SECTOR);
        bad = 0;
        for (int i = 0; i < delivered.size(); i++) if (delivered[i] != 8'(i)) bad++;
        chk("stream_order", bad, 0);
        chk("stream_done_count", done_seen, 1);
        chk("stream_sec_cnt", dut.sec_cnt_reg, 0);
        $display("stream: delivered %0d bytes, done pulses %0d", delivered.size(), done_seen);

        // ---------------- mid-sector flush ----------------
        do_reset();
        for (int i = 0; i < 302; i++) drive(1'b0, 1'b0, i < 300, 8'(i), 1'b1);
        chk("flush_pre_len", delivered.size(), 300);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("flush_done_none", done_seen, 0);
        delivered.delete();
        for (int i = 0; i < SECTOR + 4; i++) drive(1'b0, 1'b0, i < SECTOR, 8'(i ^ 8'h5A), 1'b1);
        chk("flush_post_len", delivered.size(), SECTOR);
        chk("flush_done_count", done_seen, 1);
        $display("flush: second sector %0d bytes, done pulses %0d", delivered.size(), done_seen);

        // ---------------- randomized traffic against the model ----------------
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(1'b0, ($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 7), 8'($urandom),
                  1'($urandom_range(0, 1)));
        end
        $display("random: 3000 cycles, %0d bytes delivered", delivered.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
